// File: rtl/cic_integrator_decim.sv
// Two cascaded integrators with modulo-DECIM sample counter; emits one
// full-width integrator value per DECIM accepted samples for the comb stage.
module cic_integrator_decim #(
    parameter int unsigned NIN   = 16,
    parameter int unsigned NACC  = 40,
    parameter int unsigned DECIM = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_valid,
    input  logic signed [NIN-1:0]  din,
    output logic                   dout_valid,
    output logic signed [NACC-1:0] dout
);

    localparam int unsigned   CNT_W    = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic signed [NACC-1:0] i1_q, i1_d;
    logic signed [NACC-1:0] i2_q, i2_d;
    logic signed [NACC-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic signed [NACC-1:0] din_ext;

    assign din_ext = {{(NACC - NIN){din[NIN-1]}}, din};

    // i2 integrates the pre-update i1; all sums wrap modulo 2^NACC
    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (din_valid) begin
            i1_d = i1_q + din_ext;
            i2_d = i2_q + i1_q;
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                dout_d  = i2_q + i1_q;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q    <= '0;
            i2_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: doc/cic_integrator_decim.md
# cic_integrator_decim

Integrator-and-decimation front half of the two-stage CIC decimator. It accumulates mixer-rate samples through two cascaded integrators, counts accepted samples, and every `DECIM` samples emits one full-width integrator value with a single-cycle strobe. That strobe drives the `en` input of the downstream two-stage comb, and `dout` feeds the comb's `din`, so `NACC` must equal the comb's `NIN`.

## Interface
- `NIN`, 16: signed input sample width (mixer output).
- `NACC`, 40: integrator/output width; must satisfy `NACC >= NIN + 2*ceil(log2(DECIM))`.
- `DECIM`, 400: decimation ratio R (320 kHz mixing rate / 800 Hz output rate); legal range 2..65535.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `din_valid`  in  1  one-cycle strobe marking a new input sample; may be high on consecutive cycles.
- `din`  in  `NIN`  signed input sample; sampled only when `din_valid` = 1.
- `dout_valid`  out  1  one-cycle strobe marking a new decimated sample; connects to the comb's `en`.
- `dout`  out  `NACC`  signed decimated integrator value; held between strobes.

## Operation
- State:
  - `i1`, `i2`: `NACC`-bit signed integrators.
  - `cnt`: counter, 0..DECIM-1.
  - `dout_r`: output register.
  - `valid_r`: output strobe register.
- On a cycle with `din_valid` = 1:
  - `i1 <= i1 + sext(din)`.
  - `i2 <= i2 + i1`, using the pre-update `i1` (pipelined integrator; one sample of extra delay is intended).
  - If `cnt == DECIM-1`: `cnt <= 0`, `dout_r <= i2 + i1` (the new `i2` value), `valid_r <= 1`.
  - Otherwise: `cnt <= cnt + 1`, `valid_r <= 0`.
- On a cycle with `din_valid` = 0: `i1`, `i2`, `cnt` and `dout_r` hold; `valid_r <= 0`.
- Arithmetic:
  - All sums are two's-complement modulo 2^NACC.
  - Wrap-around is required; no saturation and no overflow flag.
  - The comb's differencing cancels the wrap, provided the `NACC` sizing rule holds.
- Decimation phase is set only by reset: the first output follows the DECIM-th accepted sample after reset.
- No state machine beyond the modulo-DECIM counter; the block has no idle or run mode.

## Timing
- Reset (`rst` = 1 at a rising edge):
  - `i1 = i2 = 0`, `cnt = 0`, `dout = 0`, `dout_valid = 0`.
  - Reset overrides a simultaneous `din_valid`; that sample is dropped.
- Reset mid-operation discards partial accumulation. The next output follows exactly DECIM accepted samples after reset release.
- Latency: `dout`/`dout_valid` update on the rising edge that samples the DECIM-th `din_valid`, so they are visible the following cycle.
- `dout_valid` is high for exactly one cycle per DECIM accepted samples, regardless of gaps in `din_valid`.
- `dout` changes only on the edge that raises `dout_valid`.
- Back-to-back `din_valid` every clock is supported; minimum spacing between `dout_valid` pulses is DECIM cycles.
- Counter wrap (`cnt == DECIM-1` with `din_valid`) and integrator update happen in the same cycle; there is no skipped sample.

## Test plan
- Reset values: hold `rst` for 3 cycles with `din_valid` toggling -> `dout = 0`, `dout_valid = 0`, and no strobe during reset.
- Constant input, DECIM=4: `din = 1` with `din_valid` every cycle -> `dout_valid` pulses every 4 cycles, and `dout` = 6, 28, 66, 120. When chained with the comb, the differences settle to 16 = R².
- Gapped input, DECIM=4: same stream with `din_valid` high 1 cycle in 3 -> identical `dout` sequence; pulses spaced 12 cycles apart.
- Negative full-scale and wrap, NACC=20, NIN=16, DECIM=4: `din = -32768` sustained past integrator wrap -> `dout` equals the golden model mod 2^20, and the comb output is a constant -32768·16 mod 2^20.
- Reset mid-frame, DECIM=4: assert `rst` after 2 samples, then feed `din = 1` -> first `dout_valid` comes after 4 post-reset samples with `dout = 6`.
- Random stimulus, default parameters: 10k random `din` and random `din_valid` gaps -> every `dout` and strobe position matches a bit-exact reference model.
